// File: rtl/stream_pkg.sv
// Shared definitions for the stream muxing/arbitration blocks: mode encodings,
// packet-lock state type and a reusable round-robin pick function.
package stream_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Widest valid vector rr_pick can search; callers zero-extend into it.
  localparam int RR_MAX_CH = 32;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_e;

  // Index of the first set bit of valid, searching from (ptr+1) mod nch
  // upward with wrap-around. Returns 0 when nothing is valid.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                 input int ptr,
                                 input int nch);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_CH; k++) begin
      idx = (ptr + k) % nch;
      if ((k <= nch) && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid channel after ptr, with wrap.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [RR_MAX_CH-1:0] valid_ext;

  always_comb begin
    valid_ext            = '0;
    valid_ext[NCH-1:0]   = valid;
    grant                = SELW'(rr_pick(valid_ext, int'(ptr), NCH));
  end

  assign grant_valid = |valid;

endmodule

// File: rtl/stream_mux_arb.sv
// Registered NCH:1 stream mux: static select or round-robin with packet lock,
// feeding a single output register with valid/ready handshake.
//
// state     | meaning
// ST_IDLE   | no packet in progress, round-robin picks the next channel
// ST_LOCKED | mid-packet, grant held on 'locked' until a beat with last=1
module stream_mux_arb
  import stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  lock_state_e     state, state_nxt;
  logic [SELW-1:0] locked, locked_nxt;
  logic [SELW-1:0] rr_ptr, rr_ptr_nxt;
  logic [SELW-1:0] arb_grant, grant;
  logic            arb_valid, grant_valid;
  logic            load_en, take;
  logic            g_valid, g_last;
  logic [WIDTH-1:0] g_data;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .valid       (in_valid),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Static select overrides any lock; out-of-range sel grants nothing.
  always_comb begin
    grant       = arb_grant;
    grant_valid = arb_valid;
    if (mode == MODE_STATIC) begin
      grant       = sel;
      grant_valid = ({1'b0, sel} < NCH_W);
    end else if (state == ST_LOCKED) begin
      grant       = locked;
      grant_valid = 1'b1;
    end
  end

  assign load_en = ~out_valid | out_ready;

  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        g_valid     = in_valid[i];
        g_last      = in_last[i];
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load_en & grant_valid;
      end
    end
  end

  assign take = load_en & grant_valid & g_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= take;
      if (take) begin
        out_data <= g_data;
        out_last <= g_last;
        out_ch   <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      locked <= '0;
      rr_ptr <= SELW'(NCH-1);
    end else begin
      state  <= state_nxt;
      locked <= locked_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Leaving round-robin mid-packet simply drops the lock.
  always_comb begin
    state_nxt  = state;
    locked_nxt = locked;
    rr_ptr_nxt = rr_ptr;
    if (mode == MODE_STATIC) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            rr_ptr_nxt = grant;
            if (!g_last) begin
              state_nxt  = ST_LOCKED;
              locked_nxt = grant;
            end
          end
        end
        ST_LOCKED: begin
          if (take && g_last) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios plus randomized
// traffic against a transaction-level reference model; also an NCH=3 build.
module tb_stream_mux_arb;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;

  logic        b_mode, b_ov, b_ol, b_ordy;
  logic [1:0]  b_sel, b_oc;
  logic [2:0]  b_valid, b_last, b_ready;
  logic [23:0] b_data;
  logic [7:0]  b_od;

  int total = 0;
  int bad   = 0;

  logic [7:0] d [4];

  // reference model state
  logic       m_ov, m_last;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr, m_lock;
  logic [3:0] e_ready;
  int         e_g;
  bit         e_gv, e_can;

  stream_mux_arb #(.WIDTH(8), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_valid(b_valid), .in_last(b_last), .in_data(b_data), .in_ready(b_ready),
    .out_valid(b_ov), .out_data(b_od), .out_last(b_ol), .out_ch(b_oc),
    .out_ready(b_ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic md, input logic [1:0] s, input logic [3:0] v,
                       input logic [3:0] l, input logic ordy);
    mode = md; sel = s; in_valid = v; in_last = l; out_ready = ordy;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = d[i];
  endtask

  task automatic model_reset();
    m_ov = 0; m_last = 0; m_data = 0; m_ch = 0; m_ptr = 3; m_lock = -1;
  endtask

  // Who is eligible this cycle, from the rules: static sel, held lock, or
  // the first valid channel after the last winner.
  task automatic model_comb();
    int c;
    e_can = !m_ov || out_ready;
    e_gv = 0; e_g = 0;
    if (mode == 1'b0) begin
      e_g = int'(sel); e_gv = 1;
    end else if (m_lock >= 0) begin
      e_g = m_lock; e_gv = 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!e_gv && in_valid[c]) begin e_g = c; e_gv = 1; end
      end
    end
    e_ready = (e_can && e_gv) ? 4'(1 << e_g) : 4'b0;
  endtask

  task automatic half();
    @(negedge clk);
    model_comb();
  endtask

  task automatic edge_step();
    bit xfer;
    @(posedge clk);
    xfer = e_ready[e_g] && in_valid[e_g];
    if (e_can) begin
      m_ov = xfer;
      if (xfer) begin m_data = d[e_g]; m_last = in_last[e_g]; m_ch = 2'(e_g); end
    end
    if (mode == 1'b1 && xfer) begin
      if (m_lock < 0) begin
        m_ptr = e_g;
        if (!in_last[e_g]) m_lock = e_g;
      end else if (in_last[e_g]) begin
        m_lock = -1;
      end
    end
    if (mode == 1'b0) m_lock = -1;
    #1;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    drive(1'b1, 2'd0, 4'b0, 4'b0, 1'b1);
    b_mode = 1'b0; b_sel = 2'd0; b_valid = 3'b0; b_last = 3'b0; b_data = 24'h0; b_ordy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      half();
      total++;
      if (in_ready !== 4'b0) begin bad++; $display("FAIL reset_ready cyc%0d got=%b want=0000", k, in_ready); end
      edge_step();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
        bad++; $display("FAIL reset_out cyc%0d got v=%b d=%h want v=0 d=00", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_static_backpressure();
    apply_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    d[2] = 8'hA5;
    drive(1'b0, 2'd2, 4'b1111, 4'b0000, 1'b0);
    half();
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL static_rdy0 got=%b want=0100", in_ready); end
    edge_step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      bad++; $display("FAIL static_first got v=%b d=%h ch=%0d want v=1 d=a5 ch=2", out_valid, out_data, out_ch);
    end
    d[2] = 8'h3C;
    drive(1'b0, 2'd2, 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      half();
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL static_hold_rdy cyc%0d got=%b want=0000", k, in_ready); end
      edge_step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
        bad++; $display("FAIL static_hold cyc%0d got v=%b d=%h ch=%0d want v=1 d=a5 ch=2", k, out_valid, out_data, out_ch);
      end
    end
    drive(1'b0, 2'd2, 4'b1111, 4'b0000, 1'b1);
    half();
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL static_release_rdy got=%b want=0100", in_ready); end
    edge_step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd2) begin
      bad++; $display("FAIL static_second got v=%b d=%h ch=%0d want v=1 d=3c ch=2", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_fairness();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      drive(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1);
      half();
      total++;
      if (in_ready !== 4'(1 << seq[k])) begin bad++; $display("FAIL rr_ready beat%0d got=%b want ch%0d", k, in_ready, seq[k]); end
      edge_step();
      total++;
      if (out_valid !== 1'b1 || out_ch !== 2'(seq[k]) || out_data !== d[seq[k]]) begin
        bad++; $display("FAIL rr_order beat%0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                        k, out_valid, out_ch, out_data, seq[k], d[seq[k]]);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] vt [5] = '{4'b0010, 4'b1011, 4'b1011, 4'b1001, 4'b0001};
    logic [3:0] lt [5] = '{4'b0000, 4'b1001, 4'b1011, 4'b1001, 4'b0001};
    int         ct [5] = '{1, 1, 1, 3, 0};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      drive(1'b1, 2'd0, vt[k], lt[k], 1'b1);
      half();
      total++;
      if (in_ready !== 4'(1 << ct[k])) begin bad++; $display("FAIL lock_ready beat%0d got=%b want ch%0d", k, in_ready, ct[k]); end
      edge_step();
      total++;
      if (out_ch !== 2'(ct[k]) || out_last !== lt[k][ct[k]] || out_data !== d[ct[k]]) begin
        bad++; $display("FAIL lock_order beat%0d got ch=%0d last=%b want ch=%0d last=%b", k, out_ch, out_last, ct[k], lt[k][ct[k]]);
      end
    end
  endtask

  task automatic test_switch_and_reset();
    apply_reset();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    drive(1'b1, 2'd0, 4'b0100, 4'b0000, 1'b1);
    half(); edge_step();
    total++;
    if (out_ch !== 2'd2) begin bad++; $display("FAIL switch_lock got ch=%0d want 2", out_ch); end
    drive(1'b0, 2'd0, 4'b0101, 4'b0000, 1'b1);
    half();
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL switch_ready got=%b want=0001", in_ready); end
    edge_step();
    total++;
    if (out_ch !== 2'd0 || out_data !== 8'h11) begin bad++; $display("FAIL switch_beat got ch=%0d d=%h want ch=0 d=11", out_ch, out_data); end
    drive(1'b1, 2'd0, 4'b0110, 4'b0110, 1'b1);
    half(); edge_step();
    total++;
    if (out_ch !== 2'd1) begin bad++; $display("FAIL switch_unlock got ch=%0d want 1", out_ch); end
    drive(1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
    half(); edge_step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid got=%b want=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL async_reset got v=%b d=%h want v=0 d=00", out_valid, out_data);
    end
    model_reset();
    drive(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_comb();
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_ready got=%b want=0001", in_ready); end
    edge_step();
    total++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin bad++; $display("FAIL post_reset_grant got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      drive(($urandom_range(0, 4) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 3) != 0));
      half();
      total++;
      if (in_ready !== e_ready) begin bad++; $display("FAIL rand_ready cyc%0d got=%b want=%b", k, in_ready, e_ready); end
      edge_step();
      total++;
      if (out_valid !== m_ov || out_data !== m_data || out_last !== m_last || out_ch !== m_ch) begin
        bad++; $display("FAIL rand_out cyc%0d got v=%b d=%h l=%b ch=%0d want v=%b d=%h l=%b ch=%0d",
                        k, out_valid, out_data, out_last, out_ch, m_ov, m_data, m_last, m_ch);
      end
    end
  endtask

  task automatic test_nch3();
    logic [7:0] v2;
    apply_reset();
    v2 = 8'($urandom);
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111; b_last = 3'b100; b_ordy = 1'b1;
    b_data = {v2, 8'($urandom), 8'($urandom)};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (b_ready !== 3'b000) begin bad++; $display("FAIL nch3_sel3_ready cyc%0d got=%b want=000", k, b_ready); end
      @(posedge clk); #1;
      total++;
      if (b_ov !== 1'b0) begin bad++; $display("FAIL nch3_sel3_valid cyc%0d got=%b want=0", k, b_ov); end
    end
    b_sel = 2'd2;
    @(negedge clk);
    total++;
    if (b_ready !== 3'b100) begin bad++; $display("FAIL nch3_sel2_ready got=%b want=100", b_ready); end
    @(posedge clk); #1;
    total++;
    if (b_ov !== 1'b1 || b_od !== v2 || b_oc !== 2'd2 || b_ol !== 1'b1) begin
      bad++; $display("FAIL nch3_sel2_out got v=%b d=%h ch=%0d l=%b want v=1 d=%h ch=2 l=1", b_ov, b_od, b_oc, b_ol, v2);
    end
  endtask

  initial begin
    test_reset();
    test_static_backpressure();
    test_rr_fairness();
    test_packet_lock();
    test_switch_and_reset();
    test_random();
    test_nch3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised, registered successor to the team's combinational 4:1 select primitive.
- Selects one of NCH valid/ready input streams of WIDTH bits and forwards it through a single output register.
- Two modes: static select (sel port) or round-robin arbitration with packet lock (grant held until a beat with last=1).
- Sits between multiple producers (e.g. per-channel sample sources) and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (≥2).
- SELW, $clog2(NCH), width of sel/out_ch. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = static select, 1 = round-robin with packet lock
- sel  input  SELW  channel index used when mode=0
- in_valid  input  NCH  per-channel valid
- in_last  input  NCH  per-channel end-of-packet flag, qualified by in_valid
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NCH  per-channel ready (combinational)
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_last  output  1  registered last flag
- out_ch  output  SELW  registered source channel index
- out_ready  input  1  consumer ready

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=NCH-1 (channel 0 wins first), lock state=IDLE, locked channel=0.
- Load condition: load_en = ~out_valid | out_ready.
  - Transfer on input i when in_valid[i] & in_ready[i].
  - Transfer on output when out_valid & out_ready.
- in_ready[i] = load_en & (grant==i) & grant_valid. At most one bit is set. in_ready has no combinational path from in_valid of other channels in mode 0.
- Latency: 1 cycle, input accept to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Output hold: while out_valid & ~out_ready, out_data/out_last/out_ch are stable and all in_ready=0.
- Output update on the load_en cycle:
  - If an input transfer occurs: out_valid=1 and the register captures data/last/index.
  - If no input transfer occurs: out_valid=0; data fields hold their previous values.
- Mode 0 (static):
  - grant=sel; grant_valid=1 iff sel<NCH.
  - sel≥NCH (non-power-of-2 NCH) grants nothing.
  - in_last is ignored for arbitration and only passed through.
- Mode 1 (round-robin, 2-state FSM):
  - IDLE: grant = first i with in_valid[i]=1, searching (rr_ptr+1) mod NCH upward with wrap-around; grant_valid = |in_valid.
    - On a transfer with in_last=1: stay IDLE and set rr_ptr=grant.
    - On a transfer with in_last=0: go to LOCKED, store locked=grant, set rr_ptr=grant.
  - LOCKED: grant=locked, grant_valid=1; other channels are starved even if valid.
    - On a transfer from locked with in_last=1: go to IDLE.
- Mode switch: mode is sampled every cycle.
  - Switching to 0 while LOCKED forces the FSM to IDLE on the next edge; the packet is broken by the user, and this is not an error.
  - rr_ptr is unchanged by mode 0 traffic.
- Simultaneous events: output drain and input load in the same cycle are allowed; there is no bubble.
- Reset mid-packet: all state returns to reset values; the in-flight beat in the output register is discarded.

Decomposition:
- Shared package stream_pkg holds:
  - mode encodings MODE_STATIC=1'b0, MODE_RR=1'b1;
  - FSM state typedef {ST_IDLE, ST_LOCKED};
  - function rr_pick(valid, ptr) for reuse by other arbiters.
- One natural sub-module: rr_arbiter (combinational priority pick from ptr+1 with wrap, plus grant_valid). The output register, FSM and ready logic stay in the top.

Test Plan:
- Reset/idle: hold rst_n=0, then release with all in_valid=0 -> out_valid=0, in_ready=0, out_data=0 for 10 cycles.
- Static select with backpressure (mode=0, sel=2):
  - ch2 sends 0xA5, 0x3C while out_ready=0 in cycle 2 -> out_data=0xA5 held with in_ready[2]=0 until out_ready=1, then 0x3C next cycle, out_ch=2.
  - Other channels' valid beats are never accepted.
- Round-robin fairness (mode=1): all 4 channels valid, single-beat packets (last=1), out_ready=1 -> out_ch sequence 0,1,2,3,0,1; one beat per cycle.
- Packet lock (mode=1): ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch3 are valid -> out_ch=1,1,1 then 3 then 0; no interleaving.
- Mid-packet mode switch and reset:
  - Lock ch2, then set mode=0, sel=0 -> the next accepted beat comes from ch0.
  - Assert rst_n=0 while out_valid=1 -> out_valid drops asynchronously; after release the first RR grant is ch0.
- NCH=3 build: mode=0, sel=3 -> in_ready=0 and out_valid stays 0; sel=2 -> normal transfer.
